regfile_write_arbiter: RTL

//  Shares the register file's single write port (Write_Register/Write_data/Reg_write)

---
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among N_REQ writeback sources.
// Define RF_ARB_STATS_EN to add the Conflict_cnt / Drop_cnt statistics outputs.
module regfile_write_arbiter #(
  parameter int N_REQ    = 3,
  parameter int DW       = 32,
  parameter int PROT_REG = 29
) (
  input  logic                clk,
  input  logic                Reset_n,
  input  logic                Hold,
  input  logic [N_REQ-1:0]    Req_valid,
  input  logic [5*N_REQ-1:0]  Req_addr,
  input  logic [DW*N_REQ-1:0] Req_data,
  output logic [N_REQ-1:0]    Req_ready,
  output logic [4:0]          Write_Register,
  output logic [DW-1:0]       Write_data,
  output logic                Reg_write,
  output logic [2:0]          Grant_id,
  output logic                Prot_violation,
`ifdef RF_ARB_STATS_EN
  output logic [15:0]         Conflict_cnt,
  output logic [15:0]         Drop_cnt,
`endif
  output logic [2:0]          Rr_ptr
);

  logic [4:0]       w_addr [N_REQ];
  logic [DW-1:0]    w_data [N_REQ];
  logic [N_REQ-1:0] w_grant;
  logic [2:0]       w_grant_idx;
  logic [4:0]       w_sel_addr;
  logic [DW-1:0]    w_sel_data;
  logic [3:0]       w_cand;
  logic             w_found;
  logic             w_xfer;
  logic             w_prot_drop;
  logic [2:0]       w_next_ptr;

  logic [2:0]       r_rr_ptr;
  logic [4:0]       r_write_register;
  logic [DW-1:0]    r_write_data;
  logic             r_reg_write;
  logic [2:0]       r_grant_id;
  logic             r_prot_violation;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_addr[gi] = Req_addr[5*gi +: 5];
      assign w_data[gi] = Req_data[DW*gi +: DW];
    end
  endgenerate

  // Scan candidates r_rr_ptr, r_rr_ptr+1, ... (mod N_REQ); first valid one wins.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    if (Reset_n && !Hold) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_cand = {1'b0, r_rr_ptr} + 4'(k);
        if (w_cand >= 4'(N_REQ)) w_cand = w_cand - 4'(N_REQ);
        for (int j = 0; j < N_REQ; j++) begin
          if (!w_found && (w_cand == 4'(j)) && Req_valid[j]) begin
            w_found     = 1'b1;
            w_grant[j]  = 1'b1;
            w_grant_idx = 3'(j);
            w_sel_addr  = w_addr[j];
            w_sel_data  = w_data[j];
          end
        end
      end
    end
  end

  assign w_xfer      = |w_grant;
  assign w_prot_drop = w_xfer && (w_sel_addr == 5'(PROT_REG)) && (w_grant_idx != 3'd0);
  assign w_next_ptr  = (w_grant_idx == 3'(N_REQ-1)) ? 3'd0 : w_grant_idx + 3'd1;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr_ptr         <= '0;
      r_write_register <= '0;
      r_write_data     <= '0;
      r_reg_write      <= 1'b0;
      r_grant_id       <= '0;
      r_prot_violation <= 1'b0;
    end else begin
      r_reg_write      <= 1'b0;
      r_prot_violation <= 1'b0;
      if (w_xfer) begin
        r_rr_ptr         <= w_next_ptr;
        r_write_register <= w_sel_addr;
        r_write_data     <= w_sel_data;
        r_grant_id       <= w_grant_idx;
        r_reg_write      <= (w_sel_addr != 5'd0) && !w_prot_drop;
        r_prot_violation <= w_prot_drop;
      end
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;
  logic [15:0] r_drop_cnt;
  logic        w_conflict;

  assign w_conflict = !Hold && ($countones(Req_valid) >= 2);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_conflict_cnt <= '0;
      r_drop_cnt     <= '0;
    end else begin
      if (w_conflict && (r_conflict_cnt != 16'hFFFF)) r_conflict_cnt <= r_conflict_cnt + 16'd1;
      if (w_prot_drop && (r_drop_cnt != 16'hFFFF))    r_drop_cnt     <= r_drop_cnt + 16'd1;
    end
  end

  assign Conflict_cnt = r_conflict_cnt;
  assign Drop_cnt     = r_drop_cnt;
`endif

  assign Req_ready      = w_grant;
  assign Write_Register = r_write_register;
  assign Write_data     = r_write_data;
  assign Reg_write      = r_reg_write;
  assign Grant_id       = r_grant_id;
  assign Prot_violation = r_prot_violation;
  assign Rr_ptr         = r_rr_ptr;

endmodule
